// File: rtl/prbs_pkg.sv
// Shared PRBS-4 definitions: FSM state type, tap mask and next-state helper.
package prbs_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int unsigned PRBS4_W = 4;

  // Feedback taps on hist[0] and hist[1] (x^4 + x + 1)
  localparam logic [PRBS4_W-1:0] PRBS4_TAPS = 4'b0011;

  // Advance a 4-bit history: new bit s0^s1 enters at the top, oldest drops out
  function automatic logic [PRBS4_W-1:0] prbs4_next(input logic [PRBS4_W-1:0] s);
    return {^(s & PRBS4_TAPS), s[PRBS4_W-1:1]};
  endfunction

endpackage

// File: rtl/prbs4_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear applies before the increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear first, then count the same-cycle event, holding at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr) cnt_d = '0;
    if (inc && (cnt_d != '1)) cnt_d = cnt_d + W'(1);
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/prbs4_checker.sv
// Serial PRBS-4 checker: self-synchronises, flywheels its LFSR once locked,
// flags and counts bit errors, drops lock on too many errors per window.
// Optional macro PRBS_AUTO_INV_EN adds inverted-polarity detection (inv_det).
module prbs4_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned WINDOW   = 16,
  parameter int unsigned LOSS_THR = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
`ifdef PRBS_AUTO_INV_EN
  ,
  output logic             inv_det
`endif
);

  localparam int unsigned MC_W = 8;
  localparam int unsigned WB_W = $clog2(WINDOW);
  localparam int unsigned WE_W = $clog2(LOSS_THR + 1);

  localparam logic [MC_W-1:0] LOCK_V   = MC_W'(LOCK_CNT);
  localparam logic [WB_W-1:0] WIN_LAST = WB_W'(WINDOW - 1);
  localparam logic [WE_W-1:0] LOSS_V   = WE_W'(LOSS_THR);

  state_e              state_q, state_d;
  logic [PRBS4_W-1:0]  hist_q, hist_d;
  logic [2:0]          fill_q, fill_d;
  logic [MC_W-1:0]     match_q, match_d;
  logic [WB_W-1:0]     win_bit_q, win_bit_d;
  logic [WE_W-1:0]     win_err_q, win_err_d;
  logic [WE_W-1:0]     win_err_n;
  logic                locked_q, locked_d;
  logic                err_q, err_d;
  logic                err_inc, bit_inc;
  logic                pred, rx, mis;
`ifdef PRBS_AUTO_INV_EN
  logic [MC_W-1:0]     match_inv_q, match_inv_d;
  logic                inv_q, inv_d;
`endif

  // Next-state: search/fill/match in SEARCH, flywheel compare and window accounting in LOCKED
  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match_d   = match_q;
    win_bit_d = win_bit_q;
    win_err_d = win_err_q;
    err_d     = 1'b0;
    err_inc   = 1'b0;
    bit_inc   = 1'b0;
    pred      = ^(hist_q & PRBS4_TAPS);
`ifdef PRBS_AUTO_INV_EN
    match_inv_d = match_inv_q;
    inv_d       = inv_q;
    rx          = din ^ inv_q;
`else
    rx          = din;
`endif
    mis       = (rx != pred);
    win_err_n = win_err_q + WE_W'(mis);

    if (din_valid) begin
      unique case (state_q)
        SEARCH: begin
          hist_d = {din, hist_q[PRBS4_W-1:1]};
          if (fill_q < 3'd4) begin
            fill_d = fill_q + 3'd1;
          end else begin
            match_d = ((din == pred) && (hist_q != '0)) ? match_q + MC_W'(1) : '0;
`ifdef PRBS_AUTO_INV_EN
            match_inv_d = ((~din == pred) && (hist_q != '0)) ? match_inv_q + MC_W'(1) : '0;
`endif
            if (match_d == LOCK_V) begin
              state_d   = LOCKED;
              win_bit_d = '0;
              win_err_d = '0;
`ifdef PRBS_AUTO_INV_EN
              inv_d     = 1'b0;
`endif
            end
`ifdef PRBS_AUTO_INV_EN
            else if (match_inv_d == LOCK_V) begin
              // History is stored de-inverted so the flywheel runs on true data
              state_d   = LOCKED;
              win_bit_d = '0;
              win_err_d = '0;
              inv_d     = 1'b1;
              hist_d    = ~{din, hist_q[PRBS4_W-1:1]};
            end
`endif
          end
        end

        LOCKED: begin
          hist_d  = {pred, hist_q[PRBS4_W-1:1]};
          bit_inc = 1'b1;
          err_d   = mis;
          err_inc = mis;
          if (win_bit_q == WIN_LAST) begin
            win_bit_d = '0;
            win_err_d = '0;
          end else begin
            win_bit_d = win_bit_q + WB_W'(1);
            win_err_d = win_err_n;
          end
          // Loss is judged on the pre-clear count, so it beats a coincident window end
          if (win_err_n == LOSS_V) begin
            state_d = SEARCH;
            fill_d  = '0;
            match_d = '0;
`ifdef PRBS_AUTO_INV_EN
            match_inv_d = '0;
`endif
          end
        end

        default: state_d = SEARCH;
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SEARCH;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      win_bit_q <= '0;
      win_err_q <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
`ifdef PRBS_AUTO_INV_EN
      match_inv_q <= '0;
      inv_q       <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      win_bit_q <= win_bit_d;
      win_err_q <= win_err_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
`ifdef PRBS_AUTO_INV_EN
      match_inv_q <= match_inv_d;
      inv_q       <= inv_d;
`endif
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (err_inc),
    .cnt (err_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bit_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (bit_inc),
    .cnt (bit_cnt)
  );

  assign locked = locked_q;
  assign err    = err_q;
`ifdef PRBS_AUTO_INV_EN
  assign inv_det = inv_q;
`endif

endmodule
